// File: rtl/ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scan_ctrl
// Purpose  : Decodes PS/2 scan-code-set-2 byte strobes (E0 / F0 prefixes)
//            into make/break key events and queues them in a ready/valid
//            FIFO. Also tracks the currently held key, a wrapping press
//            counter and a sticky overflow flag.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_data            - byte strobe from the PS/2 receiver
//            ev_valid/ev_ready           - event handshake to the consumer
//            ev_make/ev_ext/ev_code      - head event, registered, 0 when empty
//            fifo_count                  - occupied FIFO entries
//            overflow/overflow_clr       - sticky drop flag and its clear
//            press_cnt                   - pushed make events, wraps
//            held/held_key               - currently held key {ext,code}
// Options  : `define PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of the
//            key that is already held (typematic auto-repeat).
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    input  logic [7:0]                    in_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic                          ev_make,
    output logic                          ev_ext,
    output logic [7:0]                    ev_code,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [CNT_W-1:0]              press_cnt,
    output logic                          held,
    output logic [8:0]                    held_key
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]     FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t             state, state_next;

    // Event entry layout: {make, ext, code}
    logic [9:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr, rd_ptr_next;
    logic [AW:0]        count_next;
    logic [9:0]         head_next;

    logic               gen, gen_make, gen_ext, is_ignored;
    logic [8:0]         key;
    logic               key_match, suppress, accepted;
    logic               push, pop, drop;

    // Bytes that carry no key information (BAT result, ACK, errors, ...)
    assign is_ignored = (in_data == 8'h00) || (in_data == 8'hAA) ||
                        (in_data == 8'hE1) || (in_data == 8'hEE) ||
                        (in_data == 8'hFA) || (in_data == 8'hFC) ||
                        (in_data == 8'hFE) || (in_data == 8'hFF);

    // ------------------------------------------------------------------
    // Prefix decoder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        gen        = 1'b0;
        gen_make   = 1'b0;
        gen_ext    = 1'b0;
        if (in_valid) begin
            if (in_data == 8'hE0) begin
                // A fresh E0 restarts the sequence from any state
                state_next = EXT;
            end else if (in_data == 8'hF0) begin
                case (state)
                    IDLE:    state_next = BRK;
                    EXT:     state_next = EXT_BRK;
                    default: state_next = state;
                endcase
            end else if (is_ignored) begin
                state_next = IDLE;
            end else begin
                gen        = 1'b1;
                gen_make   = (state == IDLE) || (state == EXT);
                gen_ext    = (state == EXT)  || (state == EXT_BRK);
                state_next = IDLE;
            end
        end
    end

    assign key       = {gen_ext, in_data};
    assign key_match = held && (key == held_key);

`ifdef PS2_TYPEMATIC_FILTER_EN
    // Auto-repeat of the held key produces identical makes; swallow them
    assign suppress = gen && gen_make && key_match;
`else
    assign suppress = 1'b0;
`endif

    assign accepted = gen && !suppress;
    assign pop      = ev_valid && ev_ready;
    // A simultaneous pop frees the head slot, so a full FIFO can still accept
    assign push     = accepted && ((fifo_count != FULL_COUNT) || pop);
    assign drop     = accepted && !push;

    // ------------------------------------------------------------------
    // FIFO bookkeeping and registered head
    // ------------------------------------------------------------------
    always_comb begin
        count_next  = fifo_count;
        if (push && !pop)      count_next = fifo_count + (AW+1)'(1);
        else if (!push && pop) count_next = fifo_count - (AW+1)'(1);
        rd_ptr_next = pop ? rd_ptr + AW'(1) : rd_ptr;

        // The new entry becomes the head when it lands in an otherwise
        // empty queue; it is not yet in mem, so bypass it.
        head_next = '0;
        if (count_next != '0) begin
            if (push && ((fifo_count == '0) ||
                         ((fifo_count == (AW+1)'(1)) && pop)))
                head_next = {gen_make, gen_ext, in_data};
            else
                head_next = mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {gen_make, gen_ext, in_data};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ev_valid   <= 1'b0;
            ev_make    <= 1'b0;
            ev_ext     <= 1'b0;
            ev_code    <= 8'h00;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr     <= rd_ptr_next;
            fifo_count <= count_next;
            ev_valid   <= (count_next != '0);
            {ev_make, ev_ext, ev_code} <= head_next;
        end
    end

    // ------------------------------------------------------------------
    // Statistics: overflow, press counter, held key
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            press_cnt <= '0;
            held      <= 1'b0;
            held_key  <= 9'h000;
        end else begin
            // A drop in the same cycle as a clear wins
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;

            if (push && gen_make) press_cnt <= press_cnt + CNT_W'(1);

            // Held tracking follows every decoded event, pushed or not
            if (gen && gen_make) begin
                held     <= 1'b1;
                held_key <= key;
            end else if (gen && key_match) begin
                held     <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_scan_ctrl
// Purpose  : Directed self-checking bench for ps2_scan_ctrl with
//            hand-computed expected events, counters and flags.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_ctrl;

    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_make;
    logic        ev_ext;
    logic [7:0]  ev_code;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        overflow_clr;
    logic [7:0]  press_cnt;
    logic        held;
    logic [8:0]  held_key;

    int n_total = 0;
    int n_pass  = 0;
    int exp_press = 0;

    ps2_scan_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_make      (ev_make),
        .ev_ext       (ev_ext),
        .ev_code      (ev_code),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .press_cnt    (press_cnt),
        .held         (held),
        .held_key     (held_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One-cycle byte strobe; returns on the falling edge after it was taken
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    // Check the head {make,ext,code} then pop it (called on a falling edge)
    task automatic pop_expect(input string tag, input logic [9:0] exp);
        check({tag, "_valid"}, {31'd0, ev_valid}, 32'd1);
        check(tag, {22'd0, ev_make, ev_ext, ev_code}, {22'd0, exp});
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, ev_valid}, 32'd0);
        check({tag, "_head"},  {22'd0, ev_make, ev_ext, ev_code}, 32'd0);
        check({tag, "_count"}, {28'd0, fifo_count}, 32'd0);
        check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
        check({tag, "_press"}, {24'd0, press_cnt}, 32'd0);
        check({tag, "_held"},  {22'd0, held, held_key}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        in_valid     = 1'b0;
        in_data      = 8'h00;
        ev_ready     = 1'b0;
        overflow_clr = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // ---- Make / break of 1C, held tracking ----
        send(8'h1C);
        exp_press++;
        check("t1_held_after_make", {31'd0, held}, 32'd1);
        check("t1_heldkey", {23'd0, held_key}, 32'h01C);
        send(8'hF0);
        send(8'h1C);
        check("t1_count", {28'd0, fifo_count}, 32'd2);
        check("t1_held_after_break", {31'd0, held}, 32'd0);
        check("t1_press", {24'd0, press_cnt}, exp_press);
        pop_expect("t1_ev0", {1'b1, 1'b0, 8'h1C});
        pop_expect("t1_ev1", {1'b0, 1'b0, 8'h1C});
        check("t1_empty", {31'd0, ev_valid}, 32'd0);

        // ---- Extended key E0 75 / E0 F0 75 ----
        send(8'hE0);
        send(8'h75);
        exp_press++;
        check("t2_heldkey", {23'd0, held_key}, 32'h175);
        check("t2_held", {31'd0, held}, 32'd1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("t2_held_rel", {31'd0, held}, 32'd0);
        pop_expect("t2_ev0", {1'b1, 1'b1, 8'h75});
        pop_expect("t2_ev1", {1'b0, 1'b1, 8'h75});
        check("t2_press", {24'd0, press_cnt}, exp_press);

        // ---- Typematic repeat 1C 1C 1C F0 1C ----
        send(8'h1C);
        send(8'h1C);
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_press += 1;
        check("t3_count", {28'd0, fifo_count}, 32'd2);
        check("t3_press", {24'd0, press_cnt}, exp_press);
        pop_expect("t3_ev0", {1'b1, 1'b0, 8'h1C});
        pop_expect("t3_ev1", {1'b0, 1'b0, 8'h1C});
`else
        exp_press += 3;
        check("t3_count", {28'd0, fifo_count}, 32'd4);
        check("t3_press", {24'd0, press_cnt}, exp_press);
        pop_expect("t3_ev0", {1'b1, 1'b0, 8'h1C});
        pop_expect("t3_ev1", {1'b1, 1'b0, 8'h1C});
        pop_expect("t3_ev2", {1'b1, 1'b0, 8'h1C});
        pop_expect("t3_ev3", {1'b0, 1'b0, 8'h1C});
`endif
        check("t3_held", {31'd0, held}, 32'd0);

        // ---- Overflow, clear priority, full push+pop ----
        for (int i = 0; i <= FIFO_DEPTH; i++) send(8'h10 + 8'(i));
        exp_press += FIFO_DEPTH;
        check("t4_count_full", {28'd0, fifo_count}, FIFO_DEPTH);
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        check("t4_press", {24'd0, press_cnt}, exp_press);
        check("t4_heldkey_dropped", {23'd0, held_key}, 32'h018);
        // Drop coinciding with a clear: the set must win
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h19; overflow_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00; overflow_clr = 1'b0;
        check("t4_ovf_set_wins", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        // Push and pop together while full
        check("t4_head_before", {22'd0, ev_make, ev_ext, ev_code}, {22'd0, 1'b1, 1'b0, 8'h10});
        in_valid = 1'b1; in_data = 8'h20; ev_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
        exp_press++;
        check("t4_count_pp", {28'd0, fifo_count}, FIFO_DEPTH);
        check("t4_ovf_pp", {31'd0, overflow}, 32'd0);
        check("t4_press_pp", {24'd0, press_cnt}, exp_press);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [7:0] c;
            c = (i < FIFO_DEPTH - 1) ? 8'h11 + 8'(i) : 8'h20;
            pop_expect($sformatf("t4_drain%0d", i), {1'b1, 1'b0, c});
        end
        check("t4_empty_count", {28'd0, fifo_count}, 32'd0);
        check("t4_empty_head", {22'd0, ev_valid, ev_make, ev_ext, ev_code}, 32'd0);

        // ---- Ignored bytes, FE cancels a pending E0 ----
        send(8'hAA);
        send(8'hFA);
        check("t5_no_event", {28'd0, fifo_count}, 32'd0);
        send(8'hE0);
        send(8'hFE);
        send(8'h1C);
        exp_press++;
        check("t5_count", {28'd0, fifo_count}, 32'd1);
        pop_expect("t5_ev", {1'b1, 1'b0, 8'h1C});

        // ---- Asynchronous reset mid-sequence ----
        send(8'h2A);
        send(8'hE0);
        reset = 1'b1;
        #1;
        check_all_zero("t6_in_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_press = 0;
        send(8'h1C);
        exp_press++;
        check("t6_count", {28'd0, fifo_count}, 32'd1);
        check("t6_press", {24'd0, press_cnt}, exp_press);
        pop_expect("t6_ev", {1'b1, 1'b0, 8'h1C});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_scan_ctrl.md
Name: ps2_scan_ctrl

Overview:
- Sits downstream of the PS/2 byte receiver; consumes one-cycle byte strobes (scan code set 2).
- Decodes E0/F0 prefix sequences into make/break key events and suppresses typematic repeats.
- Buffers events in a ready/valid FIFO and maintains press statistics for the consumer, such as the display/ASCII logic or the CPU MMIO.

Parameters:
- FIFO_DEPTH, 8: event FIFO entries; power of 2, ≥2.
- CNT_W, 8: width of press_cnt.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  one-cycle strobe: in_data holds a received byte.
- in_data  in  8  received scan byte.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready.
- ev_make  out  1  1 = make (press), 0 = break (release).
- ev_ext  out  1  1 = E0-extended code.
- ev_code  out  8  scan code, prefixes stripped.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: an event was dropped.
- overflow_clr  in  1  clears overflow.
- press_cnt  out  CNT_W  count of pushed make events, wraps.
- held  out  1  a key is currently held.
- held_key  out  9  {ext,code} of the held key.

Behaviour:
- Reset (async): FSM=IDLE, FIFO empty, ev_valid=0, ev_make/ev_ext/ev_code=0, fifo_count=0, overflow=0, press_cnt=0, held=0, held_key=0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). The FSM acts only when in_valid=1.
- Byte E0, any state: go to EXT (a prefix restarts the sequence).
- Byte F0: IDLE→BRK, EXT→EXT_BRK, BRK→BRK, EXT_BRK→EXT_BRK.
- Bytes 00, AA, E1, EE, FA, FC, FE, FF: dropped, no event, FSM→IDLE.
- Any other byte generates an event {make,ext,code}, then FSM→IDLE:
  - from IDLE: {1,0,b}
  - from EXT: {1,1,b}
  - from BRK: {0,0,b}
  - from EXT_BRK: {0,1,b}
- Make event: held_key←{ext,code}, held←1. press_cnt increments only if the event is pushed.
- Break event: pushed; if {ext,code}==held_key and held=1, then held←0. A non-matching break leaves held unchanged.
- FIFO push: event generated and (fifo_count<FIFO_DEPTH or a pop in the same cycle).
- FIFO pop: ev_valid & ev_ready.
- Full with no pop: event dropped; overflow←1; press_cnt not incremented; held/held_key still updated.
- overflow_clr and a new overflow in the same cycle: set wins.
- Push and pop in the same cycle: fifo_count unchanged, including when full (accepted) and when count=1.
- Pop when empty: ignored.
- Latency: in_valid at edge N, FIFO empty → ev_valid=1 with the event after edge N. ev_* are registered from the head entry.
- Empty FIFO: ev_make/ev_ext/ev_code driven 0.
- Pointers wrap modulo FIFO_DEPTH. press_cnt wraps from 2^CNT_W−1 to 0.
- Reset asserted mid-sequence, e.g. after E0: FSM returns to IDLE, all queued events lost.

Optional Feature:
- Macro PS2_TYPEMATIC_FILTER_EN.
- Defined: a make event whose {ext,code}==held_key while held=1 is suppressed: no push, no press_cnt increment, no overflow effect.
- Undefined: every make event is pushed and counted; held/held_key tracking is unchanged.

Test Plan:
- Bytes 1C, F0, 1C, no backpressure → two events {1,0,1C} then {0,0,1C}; press_cnt=1; held=1 then 0.
- E0 75 E0 F0 75 → {1,1,75}, {0,1,75}; held_key=0x175, then held=0.
- Filter on: 1C 1C 1C F0 1C → exactly 2 events, press_cnt=1. Filter off: 4 events, press_cnt=3.
- ev_ready=0, push FIFO_DEPTH+1 makes → fifo_count=8, overflow=1, 9th event absent. Then overflow_clr pulse → overflow=0. Full FIFO with push+pop in one cycle → count stays 8, new event at tail.
- AA, FA, then E0 FE 1C → no events for AA/FA/FE; 1C yields {1,0,1C} because FE returned the FSM to IDLE.
- Reset asserted after E0, then 1C → {1,0,1C}, ext=0; all outputs read 0 during reset.
